// File: rtl/uart_pkg.sv
// Shared definitions for the 115200-baud UART receiver.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit.
package uart_pkg;

   localparam int DATA_W           = 8;
   localparam int CNT_W            = 9;
   localparam int CLKS_PER_BIT_DEF = 434;   // 50 MHz / 115200
   localparam int HALF_BIT_DEF     = 217;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
      , ST_PARITY = 3'd5
`endif
   } rx_state_e;

   // Even parity holds when the data bits plus the parity bit have an even
   // number of ones.
   function automatic logic even_par_ok(input logic [DATA_W-1:0] d, input logic p);
      return ~(^d ^ p);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so a reset never looks like a start bit.
module uart_rx_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   // Double-register the line into the i_clk domain.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta <= 1'b1;
         o_q  <= 1'b1;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_115200.sv
// UART receiver, 8N1, LSB first, mid-bit sampling.
// Build option: UART_RX_PARITY_EN adds a PARITY state and the o_parity_err
// pulse; without it the receiver is plain 8N1.
module uart_rx_115200
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int HALF_BIT     = HALF_BIT_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_rx,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_frame_err,
`ifdef UART_RX_PARITY_EN
   output logic              o_parity_err,
`endif
   output logic              o_busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

   logic              rx_s;
   rx_state_e         state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [2:0]        idx, idx_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [DATA_W-1:0] data_n;
   logic              valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
   logic              pbad, pbad_n, perr_n;
`endif

   uart_rx_sync u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_rx),
      .o_q   (rx_s)
   );

   // Busy reflects any non-idle state; disabling the receiver drops it at once.
   assign o_busy = i_enable && (state != ST_IDLE);

   // State and datapath registers; reset wins over everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pbad         <= 1'b0;
         o_parity_err <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         shreg       <= shreg_n;
         o_data      <= data_n;
         o_valid     <= valid_n;
         o_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
         pbad         <= pbad_n;
         o_parity_err <= perr_n;
`endif
      end
   end

   // Next-state and pulse logic. Pulses are computed here and registered, so
   // each lasts exactly one cycle and at most one fires per frame.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = o_data;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_n  = pbad;
      perr_n  = 1'b0;
`endif
      if (!i_enable) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         idx_n   = '0;
         shreg_n = '0;
`ifdef UART_RX_PARITY_EN
         pbad_n  = 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               cnt_n = '0;
               idx_n = '0;
`ifdef UART_RX_PARITY_EN
               pbad_n = 1'b0;
`endif
               if (!rx_s) state_n = ST_START;
            end
            ST_START: begin
               if (cnt == CNT_HALF) begin
                  // Line back high at mid start bit means it was a glitch.
                  cnt_n   = '0;
                  idx_n   = '0;
                  state_n = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt_n        = '0;
                  shreg_n[idx] = rx_s;
                  if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_n = ST_PARITY;
`else
                     state_n = ST_STOP;
`endif
                  end else begin
                     idx_n = idx + 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (cnt == CNT_LAST) begin
                  cnt_n   = '0;
                  pbad_n  = ~even_par_ok(shreg, rx_s);
                  state_n = ST_STOP;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt_n = '0;
                  if (rx_s) begin
                     state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                     if (pbad) begin
                        perr_n = 1'b1;
                     end else begin
                        valid_n = 1'b1;
                        data_n  = shreg;
                     end
`else
                     valid_n = 1'b1;
                     data_n  = shreg;
`endif
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = ST_BREAK;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_BREAK: begin
               cnt_n = '0;
               if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_rx_115200.md
UART_RX_115200 -- requirements
Module: uart_rx_115200

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, i_clk cycles per bit (50 MHz / 115200).
REQ-002 Parameter HALF_BIT, default 217, cycles from start-edge detect to start-bit mid-sample.
REQ-003 i_clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_enable  input  1  receiver enable; low forces idle.
REQ-006 i_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 o_data  output  8  last received byte, held until the next valid byte.
REQ-008 o_valid  output  1  one-cycle pulse, o_data valid this cycle.
REQ-009 o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 o_busy  output  1  high in any state other than IDLE.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle latency).
REQ-012 States SHALL be IDLE, START, DATA, STOP, BREAK (plus PARITY when configured).
REQ-013 IDLE: rx_s==0 -> START, bit counter cleared to 0.
REQ-014 START: at count HALF_BIT-1, rx_s==0 -> DATA with counter 0 and bit index 0; rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: at count CLKS_PER_BIT-1, sample rx_s into bit[index], LSB first, counter 0; after index 7 -> STOP.
REQ-016 STOP: at count CLKS_PER_BIT-1, rx_s==1 -> o_data updated, o_valid pulsed, -> IDLE; rx_s==0 -> o_frame_err pulsed, o_data unchanged, -> BREAK.
REQ-017 BREAK: remain until rx_s==1, then -> IDLE; no pulses.
REQ-018 o_valid/o_frame_err SHALL be registered, asserted exactly one cycle, never simultaneously.
REQ-019 Counter SHALL be 9 bits, never exceed CLKS_PER_BIT-1, wrap to 0 on each sample.
REQ-020 A start bit SHALL be accepted in the cycle immediately after leaving STOP to IDLE (back-to-back frames, one stop bit).
REQ-021 i_enable low SHALL force IDLE, clear counter/index/shift register, drive o_valid, o_frame_err, o_busy low; o_data held.

Reset
REQ-022 i_rst SHALL force IDLE, counter 0, index 0, synchronizer flops 1, o_data 8'h00, o_valid 0, o_frame_err 0, o_busy 0.
REQ-023 Reset mid-frame SHALL discard the partial byte with no pulse; reception restarts on the next falling edge after release.
REQ-024 i_rst SHALL take priority over i_enable.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state between DATA and STOP samples an even-parity bit; mismatch pulses output o_parity_err (1 bit) instead of o_valid, with o_data unchanged.
REQ-026 UART_RX_PARITY_EN undefined: no PARITY state, no o_parity_err port, 8N1 only.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state encoding, CLKS_PER_BIT/HALF_BIT defaults, and data width 8.
REQ-028 Synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset value 1).

Verification
REQ-029 Frame 0x55, 434 cycles/bit -> single o_valid pulse, o_data=0x55, no o_frame_err.
REQ-030 i_rx low for 100 cycles then high -> returns to IDLE, no o_valid, no o_frame_err.
REQ-031 Frame 0xA3 with stop bit low, line held low a further 2000 cycles -> one o_frame_err pulse, o_data unchanged, o_busy high until the line returns high.
REQ-032 Back-to-back 0x00 then 0xFF, single stop bit -> two o_valid pulses, 10x434 cycles apart, data 0x00 then 0xFF.
REQ-033 i_rst pulsed after 4 data bits, then frame 0x3C -> no pulse for the aborted frame; o_valid with 0x3C.
REQ-034 UART_RX_PARITY_EN build: 0x81 with parity bit 1 -> o_parity_err pulse and no o_valid; 0x81 with parity bit 0 -> o_valid, o_data=0x81.
